// File: rtl/fir_filter_mac.sv
// Programmable direct-form FIR: one time-shared MAC, circular sample history, saturated Q-format output.
// Latency: valid_out pulses TAPS+2 clk_fast edges after the accepting edge; one sample per TAPS+2 cycles.
// Backpressure: ready low during a pass; valid_in while busy (or alongside CLOAD) is dropped. Option macro: FIR_FILTER_ROUND_EN.
module fir_filter_mac #(
   parameter int TAPS      = 2048,
   parameter int ADDR_W    = 11,
   parameter int COEF_FRAC = 19
) (
   input  logic              clk_fast,
   input  logic              reset,
   input  logic [15:0]       din,
   input  logic              valid_in,
   input  logic [19:0]       CIN,
   input  logic [ADDR_W-1:0] CADDR,
   input  logic              CLOAD,
   output logic [15:0]       dout,
   output logic              valid_out,
   output logic              ready
);

   localparam int ACC_W = 36 + ADDR_W;
   localparam int IDX_W = $clog2(TAPS);
   localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(TAPS - 1);
   localparam logic [ADDR_W-1:0] TAPS_A   = ADDR_W'(TAPS);
   localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(TAPS);
   localparam logic signed [ACC_W:0] SAT_MAX = 32767;
   localparam logic signed [ACC_W:0] SAT_MIN = -32768;
`ifdef FIR_FILTER_ROUND_EN
   localparam int RND_SH = (COEF_FRAC > 0) ? COEF_FRAC - 1 : 0;
   localparam logic signed [ACC_W:0] RND = (COEF_FRAC > 0) ? ((ACC_W + 1)'(1) << RND_SH) : '0;
`endif

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                   state;
   logic signed [19:0]       coef_mem [0:TAPS-1];
   logic signed [15:0]       hist_mem [0:TAPS-1];
   logic [ADDR_W-1:0]        wptr;
   logic [ADDR_W-1:0]        newest;
   logic [ADDR_W:0]          fill;
   logic [ADDR_W-1:0]        k;
   logic                     issue_done;
   logic                     rd_vld;
   logic                     tap_on;
   logic signed [19:0]       coef_q;
   logic signed [15:0]       hist_q;
   logic signed [15:0]       tap_dat;
   logic signed [35:0]       prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W:0]    acc_rnd;
   logic signed [ACC_W:0]    acc_shr;
   logic [15:0]              sat_res;
   logic [ADDR_W-1:0]        rd_idx;
   logic [31:0]              caddr_ext;
   logic                     caddr_ok;
   logic                     accept;

   assign caddr_ext = 32'(CADDR);
   assign caddr_ok  = caddr_ext < 32'(TAPS);
   assign accept    = valid_in & ~CLOAD & ready;

   // History slot of tap k counted back from the newest sample, wrapped into 0..TAPS-1
   assign rd_idx = newest - k + ((newest < k) ? TAPS_A : '0);

   // Taps beyond the fill count read as zero so a fresh history looks zero-initialised
   assign tap_dat  = tap_on ? hist_q : 16'sd0;
   assign prod     = coef_q * tap_dat;
   assign prod_ext = {{ADDR_W{prod[35]}}, prod};

   // Scale the accumulator back to the sample format and clamp to 16 bits
   always_comb begin
`ifdef FIR_FILTER_ROUND_EN
      acc_rnd = $signed({acc[ACC_W-1], acc}) + RND;
`else
      acc_rnd = $signed({acc[ACC_W-1], acc});
`endif
      acc_shr = acc_rnd >>> COEF_FRAC;
      if (acc_shr > SAT_MAX) begin
         sat_res = 16'h7fff;
      end else if (acc_shr < SAT_MIN) begin
         sat_res = 16'h8000;
      end else begin
         sat_res = acc_shr[15:0];
      end
   end

   // Coefficient writes land immediately in any state; out-of-range addresses are ignored
   always_ff @(posedge clk_fast) begin
      if (CLOAD && caddr_ok) begin
         coef_mem[CADDR[IDX_W-1:0]] <= $signed(CIN);
      end
   end

   // Accepted samples are written at the current write pointer
   always_ff @(posedge clk_fast) begin
      if (!reset && accept) begin
         hist_mem[wptr[IDX_W-1:0]] <= $signed(din);
      end
   end

   // Registered memory reads feeding the MAC, one stage behind the tap counter
   always_ff @(posedge clk_fast) begin
      coef_q <= coef_mem[k[IDX_W-1:0]];
      hist_q <= hist_mem[rd_idx[IDX_W-1:0]];
   end

   // Control FSM: accept a sample, walk all taps through the MAC, then publish the result
   always_ff @(posedge clk_fast) begin
      if (reset) begin
         state      <= IDLE;
         wptr       <= '0;
         newest     <= '0;
         fill       <= '0;
         k          <= '0;
         issue_done <= 1'b0;
         rd_vld     <= 1'b0;
         tap_on     <= 1'b0;
         acc        <= '0;
         dout       <= '0;
         valid_out  <= 1'b0;
         ready      <= 1'b1;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  newest     <= wptr;
                  wptr       <= (wptr == LAST_K) ? '0 : wptr + 1'b1;
                  if (fill != FILL_MAX) begin
                     fill <= fill + 1'b1;
                  end
                  k          <= '0;
                  issue_done <= 1'b0;
                  rd_vld     <= 1'b0;
                  acc        <= '0;
                  ready      <= 1'b0;
                  state      <= MAC;
               end
            end
            MAC: begin
               if (rd_vld) begin
                  acc <= acc + prod_ext;
               end
               if (!issue_done) begin
                  tap_on <= ({1'b0, k} < fill);
                  rd_vld <= 1'b1;
                  if (k == LAST_K) begin
                     issue_done <= 1'b1;
                  end else begin
                     k <= k + 1'b1;
                  end
               end else begin
                  rd_vld <= 1'b0;
                  state  <= OUT;
               end
            end
            OUT: begin
               dout      <= sat_res;
               valid_out <= 1'b1;
               ready     <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed bench for fir_filter_mac at TAPS=4, ADDR_W=3, COEF_FRAC=0.
// Checks reset values, impulse/step responses, saturation, strobe conflicts, busy drops and mid-pass reset.
// Expected outputs are hand-computed dot products of the loaded coefficients and the sample history.
module tb_fir_filter_mac;

   localparam int TAPS      = 4;
   localparam int ADDR_W    = 3;
   localparam int COEF_FRAC = 0;
   localparam int LAT       = TAPS + 2;

   logic              clk_fast = 1'b0;
   logic              reset;
   logic [15:0]       din;
   logic              valid_in;
   logic [19:0]       cin;
   logic [ADDR_W-1:0] caddr;
   logic              cload;
   logic [15:0]       dout;
   logic              valid_out;
   logic              ready;

   int total = 0;
   int bad   = 0;

   always #5 clk_fast = ~clk_fast;

   fir_filter_mac #(
      .TAPS      (TAPS),
      .ADDR_W    (ADDR_W),
      .COEF_FRAC (COEF_FRAC)
   ) dut (
      .clk_fast  (clk_fast),
      .reset     (reset),
      .din       (din),
      .valid_in  (valid_in),
      .CIN       (cin),
      .CADDR     (caddr),
      .CLOAD     (cload),
      .dout      (dout),
      .valid_out (valid_out),
      .ready     (ready)
   );

   task automatic tick();
      @(posedge clk_fast);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      tick();
      tick();
      chk({tag, "_dout"}, $signed(dout), 0);
      chk({tag, "_vout"}, valid_out, 0);
      chk({tag, "_rdy"}, ready, 1);
      reset = 1'b0;
   endtask

   task automatic load(input int addr, input int val);
      cload = 1'b1;
      caddr = ADDR_W'(addr);
      cin   = 20'(val);
      tick();
      cload = 1'b0;
   endtask

   task automatic quiet(input int cycles, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (valid_out) seen++;
      end
      chk({tag, "_no_vout"}, seen, 0);
   endtask

   // Send one sample, optionally strobing a junk sample inj_at cycles into the pass
   task automatic send(input int d, input int exp, input string tag, input int inj_at);
      int n;
      bit seen;
      n = 0;
      while (!ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_rdy"}, ready, 1);
      din      = 16'(d);
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         if (inj_at != 0 && n == inj_at) begin
            din      = 16'd100;
            valid_in = 1'b1;
         end
         tick();
         valid_in = 1'b0;
         n++;
         if (valid_out) seen = 1'b1;
      end
      chk({tag, "_lat"}, n, LAT);
      chk({tag, "_dout"}, $signed(dout), exp);
      chk({tag, "_rdy_out"}, ready, 1);
      tick();
      chk({tag, "_pulse"}, valid_out, 0);
      chk({tag, "_hold"}, $signed(dout), exp);
   endtask

   initial begin
      reset    = 1'b1;
      din      = '0;
      valid_in = 1'b0;
      cin      = '0;
      caddr    = '0;
      cload    = 1'b0;

      // Reset values and silence afterwards
      do_reset("rst");
      quiet(10, "rst_idle");

      // Impulse response
      load(0, 1);
      load(1, 2);
      load(2, 3);
      load(3, 4);
      send(1, 1, "imp0", 0);
      send(0, 2, "imp1", 0);
      send(0, 3, "imp2", 0);
      send(0, 4, "imp3", 0);

      // Step response from an empty history, coefficients kept across reset
      do_reset("rst_step");
      send(5, 5, "step0", 0);
      send(5, 15, "step1", 0);
      send(5, 30, "step2", 0);
      send(5, 50, "step3", 0);
      send(5, 50, "step4", 0);

      // Saturation in both directions
      do_reset("rst_sat");
      load(0, 524287);
      load(1, 0);
      load(2, 0);
      load(3, 0);
      send(32767, 32767, "sat_pos", 0);
      do_reset("rst_neg");
      send(-32768, -32768, "sat_neg", 0);

      // CLOAD wins over valid_in; out-of-range addresses write nothing
      do_reset("rst_conf");
      cload    = 1'b1;
      valid_in = 1'b1;
      caddr    = '0;
      cin      = 20'd7;
      din      = 16'd50;
      tick();
      cload    = 1'b0;
      valid_in = 1'b0;
      chk("conf_rdy", ready, 1);
      quiet(8, "conf");
      load(4, 100);
      load(7, 200);
      send(1, 7, "conf_t0", 0);
      send(0, 0, "conf_t1", 0);
      send(0, 0, "conf_t2", 0);
      send(0, 0, "conf_t3", 0);

      // A strobe while busy is dropped
      do_reset("rst_busy");
      load(0, 1);
      load(1, 2);
      load(2, 3);
      load(3, 4);
      send(1, 1, "busy0", 2);
      send(0, 2, "busy1", 0);
      send(0, 3, "busy2", 0);

      // Reset mid-pass aborts without output and empties the history
      din      = 16'd9;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_vout", valid_out, 0);
      chk("mid_rdy", ready, 1);
      quiet(10, "mid");
      send(1, 1, "mid_imp0", 0);
      send(0, 2, "mid_imp1", 0);
      send(0, 3, "mid_imp2", 0);
      send(0, 4, "mid_imp3", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_filter_mac.md
Name: fir_filter_mac

Overview:
- Programmable direct-form FIR filter with a single time-multiplexed multiply-accumulate unit.
- Coefficients are written through a load port into a coefficient memory; input samples are kept in a circular history buffer.
- Each accepted input sample starts one full pass over all taps and produces one saturated 16-bit output sample.
- Sits between the sample source and the downstream consumer, with valid strobes on both sides.

Parameters:
- TAPS, 2048, number of filter taps; valid coefficient addresses are 0..TAPS-1.
- ADDR_W, 11, width of CADDR and of the internal tap/pointer counters; must satisfy 2^ADDR_W >= TAPS.
- COEF_FRAC, 19, fractional bits of the coefficients (signed Q1.19 by default); this is the accumulator right-shift applied before output.

Ports:
- clk_fast  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  16  signed input sample.
- valid_in  in  1  sample strobe, one cycle.
- CIN  in  20  signed coefficient write data.
- CADDR  in  ADDR_W  coefficient write address.
- CLOAD  in  1  coefficient write strobe.
- dout  out  16  signed filtered output.
- valid_out  out  1  one-cycle pulse marking a new dout.
- ready  out  1  high when a sample can be accepted.

Behaviour:
- Reset (on a clock edge with reset=1):
  - dout=0, valid_out=0, ready=1.
  - State goes to IDLE; the history write pointer is set to 0; the history fill count is set to 0.
  - Coefficient memory is not affected.
  - Reset during MAC aborts the pass; no valid_out is produced.
- Coefficient load: on an edge with CLOAD=1 and CADDR<TAPS, coef[CADDR]<=CIN.
  - CADDR>=TAPS: the write is ignored.
  - A load is allowed in any state and takes effect immediately. A pass already in progress uses the new value only for taps it has not yet read; software must not load during a pass.
- Sample accept: on an edge with valid_in=1, CLOAD=0 and ready=1:
  - hist[wptr]<=din; wptr increments modulo TAPS.
  - Fill count increments, saturating at TAPS.
  - State goes to MAC; ready goes to 0.
- Ignored strobes:
  - valid_in together with CLOAD=1: the sample is not accepted; only the coefficient write happens.
  - valid_in while ready=0: the sample is dropped, with no other effect.
- MAC state:
  - Tap counter k runs 0..TAPS-1, one tap per cycle.
  - Each cycle: acc += coef[k] * hist[(newest - k) mod TAPS].
  - Taps with k >= fill count contribute 0, so the history behaves as zero-initialised after reset.
  - Memory reads are registered (one pipeline stage).
- Arithmetic:
  - Product is 36-bit signed.
  - Accumulator is 36+ADDR_W bits signed; it never overflows.
  - Result = acc arithmetically shifted right by COEF_FRAC (floor), then saturated to [-32768, 32767].
- Output and latency:
  - dout is registered and holds until the next result.
  - valid_out is high for exactly one cycle, asserted at the clock edge TAPS+2 edges after the accepting edge.
  - ready returns to 1 on that same edge, so a new sample may be accepted in the valid_out cycle.
  - Maximum throughput: one sample per TAPS+2 cycles.
- FSM: IDLE -> (accept) -> MAC -> (last tap accumulated) -> OUT (register dout, pulse valid_out) -> IDLE. Reset from any state goes to IDLE.

Optional Feature:
- Macro: FIR_FILTER_ROUND_EN.
- Defined: round-half-up, i.e. add 2^(COEF_FRAC-1) to acc before the shift, then saturate.
- Undefined: truncation (floor), as above.
- With COEF_FRAC=0 the macro has no effect.
- Example: COEF_FRAC=1, coef[0]=1, first sample din=3 -> dout=1 without the macro, 2 with it.

Test Plan (TAPS=4, COEF_FRAC=0, macro undefined unless stated):
1. Reset: assert reset for 2 cycles -> dout=0, valid_out=0, ready=1; no valid_out afterwards without input.
2. Impulse: load coef={1,2,3,4}; send din=1,0,0,0, each when ready -> dout=1,2,3,4, each valid_out exactly 6 edges after its accept.
3. Step: same coefficients, din=5 five times -> dout=5,15,30,50,50.
4. Saturation:
   - coef={524287,0,0,0}, din=32767 -> 32767.
   - After reset, din=-32768 -> -32768.
5. Strobe conflicts:
   - CLOAD=1 with valid_in=1, CADDR=0, CIN=7 -> coef[0]=7, no sample accepted, no valid_out.
   - CLOAD with CADDR=4 -> no coefficient changes.
6. Busy/reset:
   - valid_in pulsed while ready=0 -> sample dropped; the next output matches history without it.
   - reset mid-MAC -> no valid_out; the next impulse response again starts from an empty history.
